// File: rtl/uart_frame_demux_pkg.sv
// Shared word-format definitions for the UART frame mux (transmit board) and
// demux (client board): field widths, tag assignments and control-word bits.
package uart_frame_demux_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned PAYLOAD_W = WORD_W - TAG_W;

  localparam logic [TAG_W-1:0] COMMIT_TAG = 4'h0;
  localparam logic [TAG_W-1:0] PL1_POSX   = 4'h3;
  localparam logic [TAG_W-1:0] PL1_POSY   = 4'h4;
  localparam logic [TAG_W-1:0] BALL_POSX  = 4'h5;
  localparam logic [TAG_W-1:0] BALL_POSY  = 4'h6;

  // Control-word payload layout
  localparam int unsigned CTRL_SCORE_W       = 4;
  localparam int unsigned CTRL_PL1_SCORE_LSB = 0;
  localparam int unsigned CTRL_PL2_SCORE_LSB = 4;
  localparam int unsigned CTRL_POINT_BIT     = 8;
  localparam int unsigned CTRL_END_GAME_BIT  = 9;

  typedef struct packed {
    logic                    end_game;
    logic                    point;
    logic [CTRL_SCORE_W-1:0] pl2_score;
    logic [CTRL_SCORE_W-1:0] pl1_score;
  } ctrl_fields_t;

  function automatic ctrl_fields_t unpack_ctrl(input logic [PAYLOAD_W-1:0] payload);
    ctrl_fields_t f;
    f.pl1_score = payload[CTRL_PL1_SCORE_LSB +: CTRL_SCORE_W];
    f.pl2_score = payload[CTRL_PL2_SCORE_LSB +: CTRL_SCORE_W];
    f.point     = payload[CTRL_POINT_BIT];
    f.end_game  = payload[CTRL_END_GAME_BIT];
    return f;
  endfunction

endpackage

// File: rtl/uart_frame_demux_link_watchdog.sv
// Link watchdog: counts idle cycles since the last activity pulse and flags
// link loss once TIMEOUT idle cycles have accumulated (TIMEOUT >= 1).
module link_watchdog #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic activity,
  output logic link_lost
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            link_lost_q, link_lost_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (activity) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CntMax) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    // Flag follows the registered count, so it drops one edge after activity.
    link_lost_d = (idle_cnt_q == CntMax);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q  <= '0;
      link_lost_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      link_lost_q <= link_lost_d;
    end
  end

  assign link_lost = link_lost_q;

endmodule

// File: rtl/uart_frame_demux.sv
// Routes tagged 16-bit UART words into payload channels; with COMMIT_MODE=1 the
// channels are double-buffered and published atomically on each commit word.
module uart_frame_demux #(
  parameter int unsigned WORD_W      = uart_frame_demux_pkg::WORD_W,
  parameter int unsigned TAG_W       = uart_frame_demux_pkg::TAG_W,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TAG_BASE    = 3,
  parameter int unsigned COMMIT_TAG  = 0,
  parameter int unsigned COMMIT_MODE = 1,
  parameter int unsigned TIMEOUT     = 1000000,
  localparam int unsigned PAYLOAD_W  = WORD_W - TAG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic [N_CH*PAYLOAD_W-1:0] ch_data,
  output logic [N_CH-1:0]           ch_upd,
  output logic [PAYLOAD_W-1:0]      ctrl_data,
  output logic                      ctrl_strobe,
  output logic [15:0]               frame_cnt,
  output logic [7:0]                bad_tag_cnt,
  output logic                      link_lost
);

  import uart_frame_demux_pkg::*;

  logic [TAG_W-1:0]     tag;
  logic [PAYLOAD_W-1:0] payload;
  logic [N_CH-1:0]      ch_hit;
  logic                 is_commit;
  logic                 is_chan;

  logic [N_CH*PAYLOAD_W-1:0] ch_data_q, ch_data_d;
  logic [N_CH-1:0]           ch_upd_q, ch_upd_d;
  logic [PAYLOAD_W-1:0]      ctrl_data_q, ctrl_data_d;
  logic                      ctrl_strobe_q, ctrl_strobe_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic [7:0]                bad_tag_cnt_q, bad_tag_cnt_d;
  logic [N_CH*PAYLOAD_W-1:0] shadow_q, shadow_d;
  logic [N_CH-1:0]           dirty_q, dirty_d;

  assign tag     = in_data[WORD_W-1 -: TAG_W];
  assign payload = in_data[PAYLOAD_W-1:0];

  always_comb begin
    for (int k = 0; k < int'(N_CH); k++) begin
      ch_hit[k] = (tag == TAG_W'(TAG_BASE + k));
    end
    is_commit = (tag == TAG_W'(COMMIT_TAG));
    is_chan   = |ch_hit;
  end

  always_comb begin
    ch_data_d     = ch_data_q;
    ch_upd_d      = '0;
    ctrl_data_d   = ctrl_data_q;
    ctrl_strobe_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    bad_tag_cnt_d = bad_tag_cnt_q;
    shadow_d      = shadow_q;
    dirty_d       = dirty_q;

    if (in_valid) begin
      if (is_chan) begin
        for (int k = 0; k < int'(N_CH); k++) begin
          if (ch_hit[k]) begin
            if (COMMIT_MODE != 0) begin
              shadow_d[k*PAYLOAD_W +: PAYLOAD_W] = payload;
              dirty_d[k]                         = 1'b1;
            end else begin
              ch_data_d[k*PAYLOAD_W +: PAYLOAD_W] = payload;
              ch_upd_d[k]                         = 1'b1;
            end
          end
        end
      end else if (is_commit) begin
        ctrl_data_d   = payload;
        ctrl_strobe_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
        if (COMMIT_MODE != 0) begin
          // Publish every channel, even clean ones, so ch_data mirrors the shadow.
          ch_data_d = shadow_q;
          ch_upd_d  = dirty_q;
          dirty_d   = '0;
        end
      end else if (bad_tag_cnt_q != 8'hFF) begin
        bad_tag_cnt_d = bad_tag_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_data_q     <= '0;
      ch_upd_q      <= '0;
      ctrl_data_q   <= '0;
      ctrl_strobe_q <= 1'b0;
      frame_cnt_q   <= '0;
      bad_tag_cnt_q <= '0;
    end else begin
      ch_data_q     <= ch_data_d;
      ch_upd_q      <= ch_upd_d;
      ctrl_data_q   <= ctrl_data_d;
      ctrl_strobe_q <= ctrl_strobe_d;
      frame_cnt_q   <= frame_cnt_d;
      bad_tag_cnt_q <= bad_tag_cnt_d;
    end
  end

  if (COMMIT_MODE != 0) begin : g_shadow
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow_q <= '0;
        dirty_q  <= '0;
      end else begin
        shadow_q <= shadow_d;
        dirty_q  <= dirty_d;
      end
    end
  end else begin : g_direct
    assign shadow_q = '0;
    assign dirty_q  = '0;
  end

  link_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_link_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .activity (in_valid),
    .link_lost(link_lost)
  );

  assign ch_data     = ch_data_q;
  assign ch_upd      = ch_upd_q;
  assign ctrl_data   = ctrl_data_q;
  assign ctrl_strobe = ctrl_strobe_q;
  assign frame_cnt   = frame_cnt_q;
  assign bad_tag_cnt = bad_tag_cnt_q;

endmodule
